// File: rtl/hex_word_tx_pkg.sv
// Shared UART-side constants (ASCII codes, UART Lite register offsets) and
// the state encoding used by hex_word_tx.
package hex_word_tx_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  localparam logic [3:0] UART_RX_OFS   = 4'd0;
  localparam logic [3:0] UART_TX_OFS   = 4'd4;
  localparam logic [3:0] UART_STAT_OFS = 4'd8;
  localparam logic [3:0] UART_CTRL_OFS = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } hwt_state_e;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
module nibble_to_ascii
  import hex_word_tx_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) ascii_o = ASCII_0 + {4'h0, nibble_i};
    else                  ascii_o = ASCII_A + {4'h0, nibble_i} - 8'd10;
  end

endmodule

// File: rtl/hex_word_tx.sv
// Formats a word as uppercase hex (MSB nibble first, optional CR LF) and hands
// it byte by byte to the UART TX controller, waiting for each write to finish.
module hex_word_tx
  import hex_word_tx_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int GAP_CYCLES  = 0,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  output logic [7:0]        data,
  output logic              send,
  input  logic              accepted,
  output logic              busy,
  output logic              done
);

  localparam int NDIG   = DATA_W / 4;
  localparam int NBYTES = NDIG + 2 * int'(APPEND_CRLF);
  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] CR_IDX   = IDX_W'(NDIG);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  hwt_state_e        state_q;
  logic [DATA_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic [GAP_W-1:0]  gap_q;
  logic [7:0]        data_q;
  logic              send_q;
  logic              busy_q;
  logic              done_q;

  // Byte about to be presented: index 0 of the incoming word when leaving
  // IDLE, otherwise the next index of the latched word.
  logic [DATA_W-1:0] word_d;
  logic [IDX_W-1:0]  idx_d;
  logic [3:0]        nib_d;
  logic [7:0]        hex_d;
  logic [7:0]        char_d;

  assign word_d = (state_q == ST_IDLE) ? value : word_q;
  assign idx_d  = (state_q == ST_IDLE) ? '0 : idx_q + IDX_W'(1);

  always_comb begin
    nib_d = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_d == IDX_W'(k)) nib_d = word_d[(NDIG-1-k)*4 +: 4];
    end
  end

  nibble_to_ascii u_n2a (
    .nibble_i (nib_d),
    .ascii_o  (hex_d)
  );

  always_comb begin
    if (idx_d < CR_IDX)       char_d = hex_d;
    else if (idx_d == CR_IDX) char_d = ASCII_CR;
    else                      char_d = ASCII_LF;
  end

  // Outputs are loaded on entry to SEND so send is high exactly while in SEND.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      data_q  <= 8'h00;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      send_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            word_q  <= value;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            data_q  <= char_d;
            send_q  <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (accepted) begin
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else if (GAP_CYCLES == 0) begin
              idx_q   <= idx_d;
              data_q  <= char_d;
              send_q  <= 1'b1;
              state_q <= ST_SEND;
            end else begin
              gap_q   <= GAP_LOAD;
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            idx_q   <= idx_d;
            data_q  <= char_d;
            send_q  <= 1'b1;
            state_q <= ST_SEND;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data = data_q;
  assign send = send_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_hex_word_tx.sv
// Self-checking bench for hex_word_tx: three configurations, table vectors,
// random words against a string-building model, and hand-written corner cases.
module tb_hex_word_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start0, start1, start2;
  logic [31:0] value0, value1;
  logic [7:0]  value2;
  logic        acc0, acc1, acc2;
  logic [7:0]  data0, data1, data2;
  logic        send0, send1, send2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;

  hex_word_tx #(.DATA_W(32), .GAP_CYCLES(0), .APPEND_CRLF(1'b1)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .value(value0), .data(data0),
    .send(send0), .accepted(acc0), .busy(busy0), .done(done0));

  hex_word_tx #(.DATA_W(32), .GAP_CYCLES(20), .APPEND_CRLF(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .value(value1), .data(data1),
    .send(send1), .accepted(acc1), .busy(busy1), .done(done1));

  hex_word_tx #(.DATA_W(8), .GAP_CYCLES(0), .APPEND_CRLF(1'b0)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .value(value2), .data(data2),
    .send(send2), .accepted(acc2), .busy(busy2), .done(done2));

  typedef struct {
    int          inst;
    logic [31:0] val;
    int          delay;
    string       exp_s;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         cur = 0;
  int         acc_delay = 1;
  int         pending = 0;
  logic       s_smp, dn_smp, b_smp, prev_dn;
  logic [7:0] d_smp, last_d;
  logic [7:0] got[$];
  int         send_cyc[$], acc_cyc[$], done_cyc[$];
  int         hold_err, dup_err, busy_at_done, busy_after_done;
  string      crlf;

  function automatic int gap_of(input int k);
    return (k == 1) ? 20 : 0;
  endfunction

  function automatic int ndig_of(input int k);
    return (k == 2) ? 2 : 8;
  endfunction

  // Reference: hex digits of the word, most significant first, then CR LF.
  function automatic string model(input logic [31:0] v, input int ndig, input bit with_crlf);
    string r;
    int    nib;
    r = "";
    for (int i = 0; i < ndig; i++) begin
      nib = int'((v >> (4 * (ndig - 1 - i))) & 32'hF);
      r = {r, $sformatf("%c", (nib < 10) ? 48 + nib : 55 + nib)};
    end
    if (with_crlf) r = {r, crlf};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic drive_start(input int k, input logic [31:0] v, input logic s);
    case (k)
      0:       begin value0 = v;      start0 = s; end
      1:       begin value1 = v;      start1 = s; end
      default: begin value2 = v[7:0]; start2 = s; end
    endcase
  endtask

  task automatic drive_acc(input logic v);
    case (cur)
      0:       acc0 = v;
      1:       acc1 = v;
      default: acc2 = v;
    endcase
  endtask

  // One clock: sample the active instance, log sends/dones, auto-accept.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (cur)
      0:       begin s_smp = send0; d_smp = data0; dn_smp = done0; b_smp = busy0; end
      1:       begin s_smp = send1; d_smp = data1; dn_smp = done1; b_smp = busy1; end
      default: begin s_smp = send2; d_smp = data2; dn_smp = done2; b_smp = busy2; end
    endcase
    acc0 = 1'b0; acc1 = 1'b0; acc2 = 1'b0;
    if (prev_dn === 1'b1) busy_after_done = int'(b_smp);
    prev_dn = dn_smp;
    if (dn_smp === 1'b1) begin
      done_cyc.push_back(cyc);
      busy_at_done = int'(b_smp);
    end
    if (pending > 0) begin
      if (s_smp === 1'b1)        dup_err++;
      else if (d_smp !== last_d) hold_err++;
      pending--;
      if (pending == 0) begin
        drive_acc(1'b1);
        acc_cyc.push_back(cyc);
      end
    end else if (s_smp === 1'b1) begin
      got.push_back(d_smp);
      send_cyc.push_back(cyc);
      last_d  = d_smp;
      pending = acc_delay;
    end
  endtask

  task automatic run_msg(input int k, input logic [31:0] val, input int delay, input string exp_s,
                         input string tag, input int inject_at, input int reset_at);
    int st;
    bit injected, aborted;
    cur = k; acc_delay = delay; pending = 0; prev_dn = 1'b0;
    got.delete(); send_cyc.delete(); acc_cyc.delete(); done_cyc.delete();
    hold_err = 0; dup_err = 0; busy_at_done = -1; busy_after_done = -1;
    injected = 0; aborted = 0;
    drive_start(k, val, 1'b1);
    st = cyc;
    tick();
    drive_start(k, val, 1'b0);
    check({tag, " busy_after_start"}, b_smp, 1);
    for (int n = 0; n < 3000 && done_cyc.size() == 0 && !aborted; n++) begin
      if (inject_at >= 0 && !injected && got.size() == inject_at) begin
        injected = 1;
        drive_start(k, 32'hDEADBEEF, 1'b1);
        tick();
        drive_start(k, 32'hDEADBEEF, 1'b0);
      end else if (reset_at >= 0 && got.size() == reset_at + 1 && pending > 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        pending = 0;
        aborted = 1;
        check({tag, " send_in_reset"}, s_smp, 0);
        check({tag, " busy_in_reset"}, b_smp, 0);
        check({tag, " data_in_reset"}, d_smp, 8'h00);
        repeat (30) tick();
        check({tag, " sends_after_reset"}, got.size(), reset_at + 1);
        check({tag, " done_after_reset"}, done_cyc.size(), 0);
      end else begin
        tick();
      end
    end
    if (!aborted) begin
      repeat (3) tick();
      check({tag, " done_count"}, done_cyc.size(), 1);
      check({tag, " nbytes"}, got.size(), exp_s.len());
      for (int i = 0; i < got.size() && i < exp_s.len(); i++)
        check($sformatf("%s byte%0d", tag, i), got[i], exp_s[i]);
      check({tag, " data_hold"}, hold_err, 0);
      check({tag, " single_send"}, dup_err, 0);
      if (send_cyc.size() > 0) check({tag, " start_latency"}, send_cyc[0] - st, 1);
      for (int i = 0; i + 1 < send_cyc.size() && i < acc_cyc.size(); i++)
        check($sformatf("%s acc_to_send%0d", tag, i), send_cyc[i+1] - acc_cyc[i], 1 + gap_of(k));
      if (done_cyc.size() > 0 && acc_cyc.size() > 0)
        check({tag, " done_latency"}, done_cyc[0] - acc_cyc[acc_cyc.size()-1], 1);
      check({tag, " busy_at_done"}, busy_at_done, 1);
      check({tag, " busy_after_done"}, busy_after_done, 0);
    end
    $display("msg %s inst=%0d value=%h bytes=%0d dones=%0d", tag, k, val, got.size(), done_cyc.size());
  endtask

  vec_t        tbl[6];
  int          rk;
  logic [31:0] rv;

  initial begin
    crlf = $sformatf("%c%c", 13, 10);
    reset_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    value0 = '0;   value1 = '0;   value2 = '0;
    acc0 = 1'b0;   acc1 = 1'b0;   acc2 = 1'b0;
    prev_dn = 1'b0;

    repeat (3) tick();
    check("reset data0", data0, 8'h00);
    check("reset send0", send0, 0);
    check("reset busy0", busy0, 0);
    check("reset done0", done0, 0);
    check("reset busy1", busy1, 0);
    check("reset send2", send2, 0);
    reset_n = 1'b1;
    tick();

    tbl[0] = '{0, 32'h1234ABCD, 1, {"1234ABCD", crlf}};
    tbl[1] = '{0, 32'h1234ABCD, 7, {"1234ABCD", crlf}};
    tbl[2] = '{1, 32'hFFFFFFFF, 1, {"FFFFFFFF", crlf}};
    tbl[3] = '{1, 32'h00000000, 1, {"00000000", crlf}};
    tbl[4] = '{2, 32'h0000009F, 1, "9F"};
    tbl[5] = '{0, 32'h0000000A, 3, {"0000000A", crlf}};
    for (int i = 0; i < 6; i++)
      run_msg(tbl[i].inst, tbl[i].val, tbl[i].delay, tbl[i].exp_s, $sformatf("tbl%0d", i), -1, -1);

    for (int r = 0; r < 12; r++) begin
      rk = int'($urandom_range(0, 2));
      rv = $urandom;
      if (rk == 2) rv = rv & 32'hFF;
      run_msg(rk, rv, int'($urandom_range(1, 4)), model(rv, ndig_of(rk), rk != 2),
              $sformatf("rnd%0d", r), -1, -1);
    end

    run_msg(0, 32'hCAFEF00D, 2, {"CAFEF00D", crlf}, "ignore_start", 3, -1);

    run_msg(0, 32'h01234567, 2, {"01234567", crlf}, "reset_mid", -1, 5);
    run_msg(0, 32'h01234567, 1, {"01234567", crlf}, "after_reset", -1, -1);

    // start in the done cycle must be ignored
    cur = 2; acc_delay = 1; pending = 0; prev_dn = 1'b0;
    got.delete(); send_cyc.delete(); acc_cyc.delete(); done_cyc.delete();
    drive_start(2, 32'h9F, 1'b1);
    tick();
    drive_start(2, 32'h9F, 1'b0);
    for (int n = 0; n < 100 && done_cyc.size() == 0; n++) tick();
    drive_start(2, 32'h5A, 1'b1);
    tick();
    drive_start(2, 32'h5A, 1'b0);
    repeat (4) tick();
    check("start_on_done sends", got.size(), 2);
    check("start_on_done busy", b_smp, 0);
    $display("msg start_on_done inst=2 bytes=%0d dones=%0d", got.size(), done_cyc.size());
    run_msg(2, 32'h5A, 1, "5A", "restart", -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
